// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int FETCH_WORD_W  = 32;
    localparam int FETCH_Q_DEPTH = 2;
    localparam int FETCH_CNT_W   = $clog2(FETCH_Q_DEPTH + 1);

    typedef struct packed {
        logic [FETCH_WORD_W-1:0] pc;
        logic [FETCH_WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry response queue between instruction memory and IF/ID.
// Slot 0 is always the head; a pop shifts slot 1 forward.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [FETCH_CNT_W-1:0] count
);

    fetch_entry_t           slot0_q;
    fetch_entry_t           slot1_q;
    logic [FETCH_CNT_W-1:0] count_q;
    logic                   do_pop;
    logic                   do_push;
    logic                   full;

    assign full    = (count_q == FETCH_CNT_W'(FETCH_Q_DEPTH));
    assign do_pop  = pop && (count_q != '0);
    // The upstream credit check keeps this from ever dropping a response.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= '0;
        end else if (flush) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == '0) begin
                        slot0_q <= push_entry;
                    end else begin
                        slot1_q <= push_entry;
                    end
                    count_q <= count_q + FETCH_CNT_W'(1);
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    count_q <= count_q - FETCH_CNT_W'(1);
                end
                2'b11: begin
                    if (count_q == FETCH_CNT_W'(1)) begin
                        slot0_q <= push_entry;
                    end else begin
                        slot0_q <= slot1_q;
                        slot1_q <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = slot0_q;
    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues reads to a 1-cycle
// synchronous instruction memory and presents buffered results to IF/ID.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                WORD_W   = FETCH_WORD_W,
    parameter int                ADDR_W   = 10,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] instruction,
    output logic              valid
);

    logic [WORD_W-1:0]      fpc_q;
    logic [WORD_W-1:0]      req_pc_q;
    logic                   req_q;
    logic                   pop;
    logic                   push;
    logic                   issue;
    logic [2:0]             occupancy;
    logic [FETCH_CNT_W-1:0] buf_count;
    fetch_entry_t           head;
    fetch_entry_t           push_entry;

    assign valid = (buf_count != '0);
    assign pop   = valid && !stall && !branch_taken;
    assign push  = req_q && !branch_taken;

    // Credit check: queued + in-flight, minus what leaves this cycle, must
    // leave room for the response to the read issued now.
    assign occupancy = {1'b0, buf_count} + {2'b00, req_q};
    assign issue     = !branch_taken && (occupancy <= ({2'b00, pop} + 3'd1));

    assign push_entry.pc    = req_pc_q;
    assign push_entry.instr = imem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q    <= RESET_PC;
            req_q    <= 1'b0;
            req_pc_q <= '0;
        end else if (branch_taken) begin
            fpc_q <= branch_target;
            req_q <= 1'b0;
        end else begin
            req_q <= issue;
            if (issue) begin
                fpc_q    <= fpc_q + WORD_W'(1);
                req_pc_q <= fpc_q;
            end
        end
    end

    fetch_buffer u_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (branch_taken),
        .head       (head),
        .count      (buf_count)
    );

    assign imem_addr   = fpc_q[ADDR_W-1:0];
    assign pc_out      = valid ? head.pc : '0;
    assign instruction = valid ? head.instr : '0;

endmodule
